volo_spi_master_gen: RTL and testbench
======================================

# volo_spi_master_gen

Parametrised, runtime-configurable SPI master for the radio controller; the successor to the fixed-length single-MISO SPI I/O engine. It supports a 1..MAX_LEN bit transfer length, a programmable SCLK divider, all four CPOL/CPHA modes, MSB- or LSB-first order, and NUM_RX parallel MISO channels captured in lockstep. It sits between the radio register-access logic and the RF/ADC chip SPI pins. Per-device chip-select muxing stays in user logic.

## Interface
- MAX_LEN, 32, maximum bits per transfer; width of each data word.
- NUM_RX, 4, number of MISO inputs and receive channels.
- DIV_W, 8, width of clkdiv.

- sys_clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sys_ce  in  1  clock enable; when low, all state holds.
- go  in  1  start request; rising edge detected.
- xfer_len  in  6  bits per transfer; 0 or >MAX_LEN clamps to MAX_LEN.
- clkdiv  in  DIV_W  SCLK half-period H = clkdiv+1 enabled cycles.
- cpol, cpha  in  1 each  SPI mode.
- lsb_first  in  1  1 = bit 0 sent and received first.
- tx_data  in  MAX_LEN  low xfer_len bits are transmitted.
- rx_data  out  NUM_RX*MAX_LEN  channel k at [k*MAX_LEN +: MAX_LEN], right-justified, upper bits 0.
- busy  out  1  high from start until done.
- done  out  1  one-enabled-cycle pulse at end of transfer.
- curbitnum  out  6  index of bit in flight (transmission order, 0..len-1); 0 when idle.
- spi_sclk, spi_mosi  out  1  serial clock and data.
- spi_cs  out  1  active-low chip select.
- spi_miso  in  NUM_RX  per-channel slave data.

## Operation
- All outputs are registered. Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, curbitnum=0, rx_data=0, FSM=IDLE.
- go_d1 updates on every enabled cycle, including while busy. A start is go & ~go_d1 while in IDLE.
- A rising edge of go while busy is dropped. Holding go high never retriggers.
- At start: latch len, H, cpol, cpha, lsb_first and tx_data into a shift register. Input changes while busy have no effect.
- FSM:
  - IDLE: sclk=latched cpol, cs=1, mosi=0.
  - On start → LEAD: H cycles, cs=0, sclk=cpol. If cpha=0, the first bit is on mosi.
  - LEAD → XFER: 2*len half-periods; sclk toggles at each half-period boundary.
  - XFER → TRAIL: H cycles, sclk=cpol, cs=0.
  - TRAIL → IDLE: cs=1, busy=0, done=1.
- Edge rules:
  - cpha=0: sample all MISO on the leading edge; shift mosi on the trailing edge, except after the last bit.
  - cpha=1: present the next bit on the leading edge; sample on the trailing edge.
- Bit order and assembly:
  - MSB-first: tx bit len-1 is sent first; the first received bit lands in rx bit len-1.
  - LSB-first: bit 0 is sent first; the first received bit lands in rx bit 0.
- rx_data holds the previous result during a transfer. All channels update atomically on the done edge.
- curbitnum increments at each bit boundary.
- The FSM uses only IDLE/LEAD/XFER/TRAIL. Unused encodings recover to IDLE.

## Timing
- With start detected at enabled edge E0, busy=1 and cs=0 are visible after E0.
- done is asserted after enabled edge E0 + (2*len+2)*H. The same edge sets busy=0 and cs=1.
- The earliest next start is the enabled cycle after done, provided go rose.
- sys_ce low stretches every interval by the number of disabled cycles. Outputs hold, including a done pulse, which extends until the next enabled edge.
- reset_n low at any point, including mid-XFER, forces reset values immediately (asynchronous). A partial transfer is discarded. Release is synchronous to sys_clk, and a go edge is needed afterwards.
- Mode 0/1 sclk idles low; mode 2/3 idles high. SCLK frequency is sys_clk/(2*H) at sys_ce=1.

## Test plan
- Mode 0, len=16, clkdiv=0, tx=0x0000A5C3, MSB-first; miso[0] looped to mosi, miso[1]=1, others 0 → mosi sequence A5C3 MSB-first, 16 rising sclk edges, done at E0+34, ch0=0x0000A5C3, ch1=0x0000FFFF, ch2/3=0.
- Mode 3, len=24, clkdiv=3, lsb_first=1; slave model returns 0x123456 LSB-first → sclk idles high, half-period 4 cycles, rx ch0=0x00123456, mosi LSB-first, done at E0+200.
- xfer_len=0 and xfer_len=40 → 32-bit transfers (done at E0+66 with clkdiv=0); xfer_len=1 → one sclk pulse, done at E0+4.
- go pulsed again mid-transfer, go held high, and xfer_len/tx_data changed mid-transfer → exactly one transfer using the latched values; rx_data unchanged until done.
- reset_n low during XFER bit 7 → cs=1, sclk=0, busy=0, rx_data=0 without waiting for a clock; the next go completes a normal transfer.
- sys_ce toggled 1/0 every cycle, mode 1, len=8, tx=0x3C → identical serial waveform in enabled cycles, done after 2x the sys_clk cycles of the sys_ce=1 run.

Source files
------------

// File: rtl/volo_spi_master_gen.sv
// volo_spi_master_gen: runtime-configurable SPI master, 1..MAX_LEN bits, all CPOL/CPHA modes, NUM_RX lockstep MISO channels
module volo_spi_master_gen #(
  parameter int MAX_LEN = 32,
  parameter int NUM_RX  = 4,
  parameter int DIV_W   = 8
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      sys_ce,
  input  logic                      go,
  input  logic [5:0]                xfer_len,
  input  logic [DIV_W-1:0]          clkdiv,
  input  logic                      cpol,
  input  logic                      cpha,
  input  logic                      lsb_first,
  input  logic [MAX_LEN-1:0]        tx_data,
  output logic [NUM_RX*MAX_LEN-1:0] rx_data,
  output logic                      busy,
  output logic                      done,
  output logic [5:0]                curbitnum,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  output logic                      spi_cs,
  input  logic [NUM_RX-1:0]         spi_miso
);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
  state_t state, state_nx;
  logic go_d1, start, hb, lead_e, last, shift_e, bit_e, samp_e;
  logic pol, pha, lsb;
  logic [DIV_W-1:0] cnt, h_l;
  logic [6:0] len, len_in;
  logic [7:0] hp;
  logic [MAX_LEN-1:0] sr, al;
  logic [NUM_RX-1:0][MAX_LEN-1:0] rx_sr;
  always_comb begin
    start   = sys_ce & go & ~go_d1 & (state == IDLE);
    hb      = cnt == h_l;
    len_in  = (xfer_len == 6'd0 || {1'b0, xfer_len} > 7'(MAX_LEN)) ? 7'(MAX_LEN) : {1'b0, xfer_len};
    al      = lsb_first ? tx_data : tx_data << (7'(MAX_LEN) - len_in);
    lead_e  = ~hp[0];
    last    = hp == {len, 1'b0} - 8'd1;
    shift_e = (state == XFER) & hb & (pha ? lead_e : ~lead_e & ~last);
    bit_e   = shift_e & (~pha | (hp != 8'd0));
    samp_e  = (state == XFER) & hb & (pha ^ lead_e);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LEAD : IDLE;
      LEAD:    state_nx = hb ? XFER : LEAD;
      XFER:    state_nx = (hb & last) ? TRAIL : XFER;
      TRAIL:   state_nx = hb ? IDLE : TRAIL;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (sys_ce) state <= state_nx;
  // sr always holds the next bit to present at its head; mosi is loaded from it
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      go_d1     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      spi_cs    <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      curbitnum <= '0;
      rx_data   <= '0;
      rx_sr     <= '0;
      sr        <= '0;
      len       <= '0;
      h_l       <= '0;
      cnt       <= '0;
      hp        <= '0;
      pol       <= 1'b0;
      pha       <= 1'b0;
      lsb       <= 1'b0;
    end else if (sys_ce) begin
      go_d1 <= go;
      done  <= 1'b0;
      if (start) begin
        len       <= len_in;
        h_l       <= clkdiv;
        pol       <= cpol;
        pha       <= cpha;
        lsb       <= lsb_first;
        cnt       <= '0;
        hp        <= '0;
        curbitnum <= '0;
        busy      <= 1'b1;
        spi_cs    <= 1'b0;
        spi_sclk  <= cpol;
        rx_sr     <= '0;
        spi_mosi  <= cpha ? 1'b0 : (lsb_first ? al[0] : al[MAX_LEN-1]);
        sr        <= cpha ? al : (lsb_first ? al >> 1 : al << 1);
      end else if (state != IDLE) begin
        cnt <= hb ? '0 : cnt + DIV_W'(1);
        if (state == XFER && hb) begin
          spi_sclk <= ~spi_sclk;
          hp       <= hp + 8'd1;
        end
        if (shift_e) begin
          spi_mosi <= lsb ? sr[0] : sr[MAX_LEN-1];
          sr       <= lsb ? sr >> 1 : sr << 1;
        end
        if (bit_e) curbitnum <= curbitnum + 6'd1;
        if (samp_e)
          for (int k = 0; k < NUM_RX; k++)
            rx_sr[k] <= lsb ? {spi_miso[k], rx_sr[k][MAX_LEN-1:1]} : {rx_sr[k][MAX_LEN-2:0], spi_miso[k]};
        if (state == TRAIL && hb) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          spi_cs    <= 1'b1;
          spi_mosi  <= 1'b0;
          curbitnum <= '0;
          for (int k = 0; k < NUM_RX; k++)
            rx_data[k*MAX_LEN +: MAX_LEN] <= lsb ? rx_sr[k] >> (7'(MAX_LEN) - len) : rx_sr[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_volo_spi_master_gen.sv
// tb_volo_spi_master_gen: scoreboard bench for volo_spi_master_gen
module tb_volo_spi_master_gen;
  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic sys_ce = 1'b1;
  logic go = 1'b0;
  logic [5:0] xfer_len = 6'd8;
  logic [7:0] clkdiv = 8'd0;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [31:0] tx_data = '0;
  logic [127:0] rx_data;
  logic busy, done, spi_sclk, spi_mosi, spi_cs;
  logic [5:0] curbitnum;
  logic [3:0] spi_miso;
  logic slv_en = 1'b0, slv = 1'b0, ce_tog = 1'b0;
  logic [31:0] sdata = 32'h0012_3456;
  int idx = 0;
  int cyc = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] c0, c1, mo; int len, lat; logic lsb;} exp_t;
  exp_t q[$];
  assign spi_miso = {2'b00, 1'b1, slv_en ? slv : spi_mosi};
  volo_spi_master_gen dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sys_ce(sys_ce), .go(go),
    .xfer_len(xfer_len), .clkdiv(clkdiv), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .curbitnum(curbitnum), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso));
  always #5 sys_clk = ~sys_clk;
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end
  initial forever begin
    @(negedge sys_clk);
    sys_ce = ce_tog ? ~sys_ce : 1'b1;
  end
  // mode-3 slave: drives the next LSB-first bit on each leading (falling) sclk edge
  initial forever begin
    @(negedge spi_sclk or posedge spi_cs);
    if (spi_cs) idx = 0;
    else if (slv_en && idx < 32) begin
      slv = sdata[idx];
      idx++;
    end
  end
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, x);
    end
  endtask
  initial begin : monitor
    logic p_cs, p_sclk, p_busy, p_done, lead;
    logic [31:0] cap_m, cap_l, mo;
    int t0, nlead;
    exp_t e;
    p_cs = 1'b1; p_sclk = 1'b0; p_busy = 1'b0; p_done = 1'b0;
    cap_m = '0; cap_l = '0; t0 = 0; nlead = 0;
    forever begin
      @(negedge sys_clk);
      if (!reset_n) begin
        p_cs = 1'b1; p_busy = 1'b0; p_done = 1'b0;
      end else begin
        if (busy && !p_busy) begin
          t0 = cyc; cap_m = '0; cap_l = '0; nlead = 0;
        end
        if (!spi_cs && !p_cs && spi_sclk != p_sclk) begin
          lead = spi_sclk != cpol;
          if (lead) nlead++;
          if (lead != cpha) begin
            cap_m = {cap_m[30:0], spi_mosi};
            cap_l = {spi_mosi, cap_l[31:1]};
          end
        end
        if (done && !p_done) begin
          if (q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
          else begin
            e = q.pop_front();
            mo = e.lsb ? cap_l >> (32 - e.len) : cap_m;
            chk("rx_ch0", rx_data[31:0], e.c0);
            chk("rx_ch1", rx_data[63:32], e.c1);
            chk("rx_ch23", rx_data[127:64], 64'h0);
            chk("mosi_seq", mo, e.mo);
            chk("lead_edges", nlead, e.len);
            chk("done_latency", t0 == 0 ? -1 : cyc - t0, e.lat);
            chk("busy_at_done", busy, 1'b0);
          end
        end
      end
      p_cs = spi_cs; p_sclk = spi_sclk; p_busy = busy; p_done = done;
    end
  end
  task automatic setup(input logic [5:0] l, input logic [7:0] d, input logic p, input logic h,
                       input logic lb, input logic [31:0] tx, input logic [31:0] e0, input int el, input int elat);
    logic [31:0] m;
    exp_t e;
    m = el == 32 ? 32'hFFFF_FFFF : (32'd1 << el) - 32'd1;
    e.c0 = e0; e.c1 = m; e.mo = tx & m; e.len = el; e.lat = elat; e.lsb = lb;
    q.push_back(e);
    xfer_len = l; clkdiv = d; cpol = p; cpha = h; lsb_first = lb; tx_data = tx;
  endtask
  task automatic wait_busy();
    for (int i = 0; i < 40 && !busy; i++) @(negedge sys_clk);
    chk("start_timeout", busy, 1'b1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge sys_clk);
    chk("done_timeout", busy, 1'b0);
    repeat (4) @(negedge sys_clk);
  endtask
  task automatic run(input logic [5:0] l, input logic [7:0] d, input logic p, input logic h,
                     input logic lb, input logic [31:0] tx, input logic [31:0] e0, input int el, input int elat);
    setup(l, d, p, h, lb, tx, e0, el, elat);
    @(negedge sys_clk);
    go = 1'b1;
    wait_busy();
    go = 1'b0;
    wait_idle();
  endtask
  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_cs", spi_cs, 1'b1);
    chk("rst_sclk_mosi", {spi_sclk, spi_mosi}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_bitnum", curbitnum, 6'd0);
    chk("rst_rx", rx_data, 128'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_no_start", busy, 1'b0);
    run(6'd16, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0000_A5C3, 32'h0000_A5C3, 16, 34);
    slv_en = 1'b1;
    run(6'd24, 8'd3, 1'b1, 1'b1, 1'b1, 32'h00AB_CDEF, 32'h0012_3456, 24, 200);
    slv_en = 1'b0;
    chk("mode3_sclk_idle", spi_sclk, 1'b1);
    run(6'd0, 8'd0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 66);
    chk("bitnum_idle", curbitnum, 6'd0);
    run(6'd40, 8'd0, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF, 32, 66);
    run(6'd1, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1, 4);
    setup(6'd8, 8'd1, 1'b0, 1'b0, 1'b0, 32'h0000_005A, 32'h0000_005A, 8, 36);
    @(negedge sys_clk);
    go = 1'b1;
    wait_busy();
    repeat (5) @(negedge sys_clk);
    go = 1'b0;
    xfer_len = 6'd3;
    tx_data = 32'h0000_00FF;
    repeat (3) @(negedge sys_clk);
    go = 1'b1;
    chk("rx_hold_mid", rx_data, {64'h0, 32'h1, 32'h1});
    wait_idle();
    repeat (10) @(negedge sys_clk);
    chk("go_held_no_retrig", busy, 1'b0);
    go = 1'b0;
    xfer_len = 6'd16; clkdiv = 8'd0; tx_data = 32'h0000_FFFF;
    @(negedge sys_clk);
    go = 1'b1;
    wait_busy();
    go = 1'b0;
    for (int i = 0; i < 100 && curbitnum != 6'd7; i++) @(negedge sys_clk);
    chk("reach_bit7", curbitnum, 6'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cs_sclk", {spi_cs, spi_sclk}, 2'b10);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rx", rx_data, 128'h0);
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("post_rst_idle", busy, 1'b0);
    run(6'd8, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0081, 32'h0000_0081, 8, 18);
    run(6'd8, 8'd0, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 32'h0000_003C, 8, 18);
    ce_tog = 1'b1;
    run(6'd8, 8'd0, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 32'h0000_003C, 8, 36);
    ce_tog = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
